// File: rtl/dmem_axil_bridge.sv
// ---------------------------------------------------------------------------
// dmem_axil_bridge
//
// Purpose:
//   Bridges the CPU core's single-word data-memory port onto an AXI4-Lite
//   master. Each load or store from the core becomes exactly one AXI4-Lite
//   transaction. Only one transaction is outstanding at a time. The pipeline
//   is stalled until the transaction has completed.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   dmem_addr_i         core byte address (latched when a request is accepted)
//   dmem_wen_i          core store request (has priority over a load)
//   dmem_write_data_i   store data (latched together with the address)
//   dmem_ren_i          core load request
//   dmem_read_data_o    last completed load data (held until the next load)
//   stall_o             pipeline hold; low only when no access is pending
//   resp_err_o          one-cycle pulse in DONE when BRESP/RRESP != OKAY
//   m_aw* / m_w* / m_b* AXI4-Lite write address, write data, write response
//   m_ar* / m_r*        AXI4-Lite read address, read data
// ---------------------------------------------------------------------------
module dmem_axil_bridge #(
  parameter int ADDR_W = 32,
  // DATA_W must be 32: the write strobe is fixed at four byte lanes.
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic              dmem_wen_i,
  input  logic [DATA_W-1:0] dmem_write_data_i,
  input  logic              dmem_ren_i,
  output logic [DATA_W-1:0] dmem_read_data_o,
  output logic              stall_o,
  output logic              resp_err_o,

  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,

  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,

  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,

  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,

  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q, bready_d;
  logic              rready_q, rready_d;

  // AW/W completion: either the handshake already happened (valid dropped)
  // or it is happening in this cycle.
  logic              aw_done, w_done;

  // Next-state and registered-output logic. Every valid/ready leaving the
  // bridge comes straight from a flop, so the AXI side sees no glitches.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    aw_done   = 1'b0;
    w_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A store wins over a simultaneous load; the load is simply dropped.
        if (dmem_wen_i) begin
          addr_d    = dmem_addr_i;
          wdata_d   = dmem_write_data_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WRITE;
        end else if (dmem_ren_i) begin
          addr_d    = dmem_addr_i;
          arvalid_d = 1'b1;
          state_d   = S_READ;
        end
      end

      S_WRITE: begin
        // AW and W are independent channels; each valid is released right
        // after its own handshake and the other one keeps waiting.
        aw_done = !awvalid_q || m_awready;
        w_done  = !wvalid_q  || m_wready;
        if (awvalid_q && m_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (m_bvalid) begin
          resp_d   = m_bresp;
          bready_d = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_READ: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          resp_d   = m_rresp;
          rready_d = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        // Single release cycle: stall is low here, so the core advances and
        // its request inputs are not looked at until we are back in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any transaction in flight:
  // all valids/readies drop at once and no response is consumed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
    end
  end

  // Stall is raised combinationally in IDLE so the core holds the request
  // in the very cycle it is presented.
  assign stall_o = ((state_q == S_IDLE) && (dmem_wen_i || dmem_ren_i)) ||
                   (state_q == S_WRITE) || (state_q == S_WRESP) ||
                   (state_q == S_READ)  || (state_q == S_RDATA);

  assign resp_err_o       = (state_q == S_DONE) && (resp_q != 2'b00);
  assign dmem_read_data_o = rdata_q;

  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = 4'b1111;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = addr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule
